// File: rtl/cdc_hndshk_pkg.sv
// -----------------------------------------------------------------------------
// cdc_hndshk_pkg
// Shared definitions for the cdc_hndshk destination-side responder.
//   stall_mode_e : backpressure pattern selector driven on cfg_mode
//   LFSR_TAPS    : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   DEFAULT_SEED : LFSR seed used when no other seed is supplied
// -----------------------------------------------------------------------------
package cdc_hndshk_pkg;

   typedef enum logic [1:0] {
      MODE_NONE   = 2'd0,
      MODE_BURST  = 2'd1,
      MODE_RANDOM = 2'd2,
      MODE_HOLD   = 2'd3
   } stall_mode_e;

   // Bit i of the mask corresponds to tap (i+1); taps 16,14,13,11.
   localparam logic [15:0] LFSR_TAPS    = 16'hB400;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/cdc_lfsr16.sv
// -----------------------------------------------------------------------------
// cdc_lfsr16
// 16-bit Fibonacci LFSR that advances every clock cycle.
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads seed
//   seed  : reset value; an all-zero seed is replaced by 16'h0001
//   q     : current LFSR state
// -----------------------------------------------------------------------------
module cdc_lfsr16
   import cdc_hndshk_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] seed_safe;
   logic        feedback;

   // All-zero is the lock-up state of an XOR LFSR, so it can never be a seed.
   assign seed_safe = (seed == 16'h0000) ? 16'h0001 : seed;
   assign feedback  = ^(q & LFSR_TAPS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= seed_safe;
      end else begin
         q <= {q[14:0], feedback};
      end
   end

endmodule

// File: rtl/cdc_hndshk_dest_responder.sv
// -----------------------------------------------------------------------------
// cdc_hndshk_dest_responder
// Destination-side responder for the CDC strobe/stall handshake. Drives a
// registered backpressure pattern, counts accepted transfers and raises sticky
// protocol-violation flags.
//   dest_clk      : clock (dest domain)
//   dest_reset_n  : asynchronous active-low reset
//   dest_strobe   : transfer request from the handshake
//   dest_stall    : registered backpressure to the handshake
//   cfg_mode      : stall pattern (stall_mode_e)
//   cfg_stall_len : BURST stall length in cycles (0 = no stall)
//   expect_count  : number of transfers expected
//   clear         : synchronous clear of rx_count, done and error flags
//   rx_count      : accepted transfers, saturating at all-ones
//   done          : sticky, rx_count reached expect_count
//   err_drop      : sticky, strobe withdrawn while stalled
//   err_overrun   : sticky, transfer accepted after done
// -----------------------------------------------------------------------------
module cdc_hndshk_dest_responder
   import cdc_hndshk_pkg::*;
#(
   parameter int          CNT_W = 16,
   parameter int          LEN_W = 8,
   parameter logic [15:0] SEED  = DEFAULT_SEED
)
(
   input  logic             dest_clk,
   input  logic             dest_reset_n,
   input  logic             dest_strobe,
   output logic             dest_stall,
   input  logic [1:0]       cfg_mode,
   input  logic [LEN_W-1:0] cfg_stall_len,
   input  logic [CNT_W-1:0] expect_count,
   input  logic             clear,
   output logic [CNT_W-1:0] rx_count,
   output logic             done,
   output logic             err_drop,
   output logic             err_overrun
);

   stall_mode_e      mode;
   logic [15:0]      lfsr_q;
   logic             unused_lfsr_hi;
   logic [LEN_W-1:0] stall_cnt;
   logic [LEN_W-1:0] stall_cnt_nxt;
   logic             stall_nxt;
   logic             accept;
   logic             count_en;
   logic             hold_pend;

   assign mode           = stall_mode_e'(cfg_mode);
   assign unused_lfsr_hi = ^lfsr_q[15:2];

   cdc_lfsr16 u_lfsr (
      .clk   (dest_clk),
      .rst_n (dest_reset_n),
      .seed  (SEED),
      .q     (lfsr_q)
   );

   // A handshake-level transfer happens whenever strobe meets no stall; the
   // BURST pattern reacts to it even when clear discards it from the counts.
   assign accept   = dest_strobe & ~dest_stall;
   assign count_en = accept & ~clear;

   always_comb begin
      stall_cnt_nxt = '0;
      stall_nxt     = 1'b0;
      case (mode)
         MODE_NONE: begin
            stall_nxt = 1'b0;
         end
         MODE_BURST: begin
            if (accept) begin
               stall_cnt_nxt = cfg_stall_len;
            end else if (stall_cnt != '0) begin
               stall_cnt_nxt = stall_cnt - LEN_W'(1);
            end
            // Stall stays high while the counter is non-zero: exactly
            // cfg_stall_len cycles after the accepting edge.
            stall_nxt = (stall_cnt_nxt != '0);
         end
         MODE_RANDOM: begin
            stall_nxt = lfsr_q[1] & lfsr_q[0];
         end
         MODE_HOLD: begin
            stall_nxt = 1'b1;
         end
         default: begin
            stall_nxt = 1'b0;
         end
      endcase
   end

   // Stall generation (not affected by clear).
   always_ff @(posedge dest_clk or negedge dest_reset_n) begin
      if (!dest_reset_n) begin
         dest_stall <= 1'b0;
         stall_cnt  <= '0;
         hold_pend  <= 1'b0;
      end else begin
         dest_stall <= stall_nxt;
         stall_cnt  <= stall_cnt_nxt;
         // Remembers a strobe that met a stall; it must still be high next edge.
         hold_pend  <= dest_strobe & dest_stall;
      end
   end

   // Transfer accounting and sticky flags.
   always_ff @(posedge dest_clk or negedge dest_reset_n) begin
      if (!dest_reset_n) begin
         rx_count    <= '0;
         done        <= 1'b0;
         err_drop    <= 1'b0;
         err_overrun <= 1'b0;
      end else if (clear) begin
         rx_count    <= '0;
         done        <= 1'b0;
         err_drop    <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (count_en && (rx_count != '1)) begin
            rx_count <= rx_count + CNT_W'(1);
         end
         if (rx_count == expect_count) begin
            done <= 1'b1;
         end
         if (count_en && done) begin
            err_overrun <= 1'b1;
         end
         if (hold_pend && !dest_strobe) begin
            err_drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cdc_hndshk_dest_responder.sv
// -----------------------------------------------------------------------------
// tb_cdc_hndshk_dest_responder
// Directed self-checking bench for cdc_hndshk_dest_responder. Expected counts
// and stall sequences are queued as stimulus is applied and compared as the
// DUT produces them.
// -----------------------------------------------------------------------------
module tb_cdc_hndshk_dest_responder;

   localparam logic [15:0] SEED = 16'hACE1;

   logic        dest_clk = 1'b0;
   logic        dest_reset_n;
   logic        dest_strobe;
   logic        dest_stall;
   logic [1:0]  cfg_mode;
   logic [7:0]  cfg_stall_len;
   logic [15:0] expect_count;
   logic        clear;
   logic [15:0] rx_count;
   logic        done;
   logic        err_drop;
   logic        err_overrun;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] model_cnt;
   logic [31:0] exp_q[$];
   logic [15:0] m;
   logic        e;
   logic        found;

   cdc_hndshk_dest_responder #(
      .CNT_W (16),
      .LEN_W (8),
      .SEED  (SEED)
   ) dut (
      .dest_clk      (dest_clk),
      .dest_reset_n  (dest_reset_n),
      .dest_strobe   (dest_strobe),
      .dest_stall    (dest_stall),
      .cfg_mode      (cfg_mode),
      .cfg_stall_len (cfg_stall_len),
      .expect_count  (expect_count),
      .clear         (clear),
      .rx_count      (rx_count),
      .done          (done),
      .err_drop      (err_drop),
      .err_overrun   (err_overrun)
   );

   always #5 dest_clk = ~dest_clk;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   task automatic tick();
      @(posedge dest_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Single accepted pulse; assumes dest_stall is low at the coming edge.
   task automatic pulse();
      dest_strobe = 1'b1;
      if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      exp_q.push_back({16'h0, model_cnt});
      tick();
      dest_strobe = 1'b0;
      check("rx_count", {16'h0, rx_count}, exp_q.pop_front());
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      model_cnt = 16'd0;
      check("clr_rx", {16'h0, rx_count}, 32'd0);
      check("clr_done", {31'h0, done}, 32'd0);
      check("clr_drop", {31'h0, err_drop}, 32'd0);
      check("clr_ovr", {31'h0, err_overrun}, 32'd0);
   endtask

   initial begin
      dest_reset_n  = 1'b0;
      dest_strobe   = 1'b0;
      cfg_mode      = 2'd0;
      cfg_stall_len = 8'd0;
      expect_count  = 16'd3;
      clear         = 1'b0;
      model_cnt     = 16'd0;

      // Reset state
      #12;
      check("rst_stall", {31'h0, dest_stall}, 32'd0);
      check("rst_rx", {16'h0, rx_count}, 32'd0);
      check("rst_done", {31'h0, done}, 32'd0);
      check("rst_drop", {31'h0, err_drop}, 32'd0);
      check("rst_ovr", {31'h0, err_overrun}, 32'd0);
      tick();
      dest_reset_n = 1'b1;

      // 1: NONE, three isolated pulses, expect=3
      for (int i = 0; i < 3; i++) begin
         pulse();
         check("t1_stall", {31'h0, dest_stall}, 32'd0);
         tick();
         check("t1_stall_gap", {31'h0, dest_stall}, 32'd0);
      end
      check("t1_done", {31'h0, done}, 32'd1);
      check("t1_drop", {31'h0, err_drop}, 32'd0);
      check("t1_ovr", {31'h0, err_overrun}, 32'd0);

      // 2: BURST len=4
      expect_count = 16'd100;
      do_clear();
      cfg_mode      = 2'd1;
      cfg_stall_len = 8'd4;
      tick();
      check("t2_pre", {31'h0, dest_stall}, 32'd0);
      pulse();
      for (int i = 0; i < 5; i++) exp_q.push_back((i < 4) ? 32'd1 : 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("t2_burst", {31'h0, dest_stall}, exp_q.pop_front());
         tick();
      end
      cfg_stall_len = 8'd0;
      pulse();
      check("t2_len0", {31'h0, dest_stall}, 32'd0);
      tick();
      check("t2_len0b", {31'h0, dest_stall}, 32'd0);
      cfg_stall_len = 8'd4;
      pulse();
      check("t2_restart", {31'h0, dest_stall}, 32'd1);
      cfg_mode = 2'd0;
      tick();
      check("t2_leave", {31'h0, dest_stall}, 32'd0);
      cfg_mode = 2'd1;
      tick();
      check("t2_cnt_clr", {31'h0, dest_stall}, 32'd0);

      // 3: HOLD, strobe held, then NONE -> exactly one accept
      cfg_mode = 2'd0;
      do_clear();
      cfg_mode = 2'd3;
      tick();
      check("t3_hold", {31'h0, dest_stall}, 32'd1);
      dest_strobe = 1'b1;
      repeat (3) tick();
      check("t3_held_rx", {16'h0, rx_count}, 32'd0);
      cfg_mode = 2'd0;
      tick();
      check("t3_release", {31'h0, dest_stall}, 32'd0);
      check("t3_norx", {16'h0, rx_count}, 32'd0);
      pulse();
      tick();
      check("t3_rx1", {16'h0, rx_count}, 32'd1);
      check("t3_drop", {31'h0, err_drop}, 32'd0);

      // 4: HOLD, strobe dropped under stall
      do_clear();
      cfg_mode = 2'd3;
      tick();
      dest_strobe = 1'b1;
      tick();
      dest_strobe = 1'b0;
      check("t4_drop_early", {31'h0, err_drop}, 32'd0);
      tick();
      check("t4_drop", {31'h0, err_drop}, 32'd1);
      repeat (2) tick();
      check("t4_sticky", {31'h0, err_drop}, 32'd1);
      check("t4_rx", {16'h0, rx_count}, 32'd0);
      do_clear();
      cfg_mode = 2'd0;
      tick();

      // 5: expect=2, three pulses -> overrun
      expect_count = 16'd2;
      do_clear();
      pulse();
      tick();
      pulse();
      check("t5_done_lat", {31'h0, done}, 32'd0);
      tick();
      check("t5_done", {31'h0, done}, 32'd1);
      check("t5_ovr0", {31'h0, err_overrun}, 32'd0);
      pulse();
      check("t5_ovr", {31'h0, err_overrun}, 32'd1);
      check("t5_rx3", {16'h0, rx_count}, 32'd3);

      // 6: RANDOM, reset mid-stall, sequence repeats; expect=0 gives done
      cfg_mode     = 2'd2;
      expect_count = 16'd0;
      dest_reset_n = 1'b0;
      tick();
      tick();
      dest_reset_n = 1'b1;
      model_cnt    = 16'd0;
      m = SEED;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back({31'h0, m[1] & m[0]});
         m = lfsr_step(m);
         tick();
         check("t6_seq_a", {31'h0, dest_stall}, exp_q.pop_front());
      end
      check("t6_done0", {31'h0, done}, 32'd1);
      check("t6_rx_a", {16'h0, rx_count}, 32'd0);
      found = 1'b0;
      for (int k = 0; k < 200; k++) begin
         e = m[1] & m[0];
         m = lfsr_step(m);
         tick();
         if (e) begin
            found = 1'b1;
            break;
         end
      end
      check("t6_found_stall", {31'h0, found}, 32'd1);
      check("t6_mid_stall", {31'h0, dest_stall}, 32'd1);
      #2;
      dest_reset_n = 1'b0;
      #1;
      check("t6_async_rst", {31'h0, dest_stall}, 32'd0);
      tick();
      tick();
      dest_reset_n = 1'b1;
      m = SEED;
      for (int i = 0; i < 20; i++) begin
         exp_q.push_back({31'h0, m[1] & m[0]});
         m = lfsr_step(m);
         tick();
         check("t6_seq_b", {31'h0, dest_stall}, exp_q.pop_front());
      end
      check("t6_rx_b", {16'h0, rx_count}, 32'd0);
      check("t6_done_b", {31'h0, done}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
